// File: rtl/sdram_chip_model.sv
// sdram_chip_model: device-side responder for a 16-bit SDRAM bus.
// Decodes CS/RAS/CAS/WE commands, keeps the mode register and per-bank rows,
// and serves single-word reads/writes from an internal byte-laned array with
// the programmed CAS latency and a read DQM latency of two.
// Optional protocol checker: define SDRAM_MODEL_CHECK_EN to enable err/err_code;
// left undefined, the checker is removed and err/err_code are tied to zero.
module sdram_chip_model #(
    parameter int MEM_AW = 14,
    parameter int TRCD   = 3
) (
    input  logic        clk_in,
    input  logic        rstn,
    inout  wire  [15:0] sd_data,
    input  logic [12:0] sd_addr,
    input  logic [1:0]  sd_ba,
    input  logic [1:0]  sd_dqm,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic        sd_cke,
    output logic        init_done,
    output logic [15:0] refresh_cnt,
    output logic        err,
    output logic [2:0]  err_code
);

    typedef enum logic [3:0] {
        CMD_LOAD_MODE  = 4'b0000,
        CMD_REFRESH    = 4'b0001,
        CMD_PRECHARGE  = 4'b0010,
        CMD_ACTIVE     = 4'b0011,
        CMD_WRITE      = 4'b0100,
        CMD_READ       = 4'b0101,
        CMD_BURST_TERM = 4'b0110,
        CMD_NOP        = 4'b0111,
        CMD_INHIBIT    = 4'b1111
    } cmd_e;

    localparam int WORDS = 1 << MEM_AW;

    cmd_e              cmd;
    logic [3:0][12:0]  row_q;
    logic [2:0]        cl_q;
    logic              init_done_q;
    logic [15:0]       refresh_q;
    logic [2:0]        eff_cl;
    logic              mode_ok;
    logic [23:0]       full_idx;
    logic [MEM_AW-1:0] acc_idx;

    logic [7:0]        mem_lo [0:WORDS-1];
    logic [7:0]        mem_hi [0:WORDS-1];
    logic [15:0]       rd_word_q;

    logic              p1_vld_q;
    logic              p1_cl3_q;
    logic              p2_vld_q;
    logic [15:0]       p2_data_q;
    logic [1:0]        dqm_q;
    logic [1:0]        oe_q;
    logic [15:0]       dout_q;

    // Command decode: clock-disabled or deselected cycles behave as no-ops
    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        cmd = CMD_NOP;
        if (sd_cke) begin
            if (sd_cs) cmd = CMD_INHIBIT;
            else       cmd = cmd_e'({1'b0, sd_ras, sd_cas, sd_we});
        end
    end

    // Column accesses before the first valid mode load run at CL=3.
    assign eff_cl   = init_done_q ? cl_q : 3'd3;
    assign mode_ok  = ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) && (sd_addr[2:0] == 3'b000);
    // Word index is {row, bank, column} keeping only the low MEM_AW bits.
    assign full_idx = {row_q[sd_ba], sd_ba, sd_addr[8:0]};
    assign acc_idx  = MEM_AW'(full_idx);

    // Per-bank row latch; a closed bank keeps its last row for stray accesses
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            row_q <= '0;
        end else if (cmd == CMD_ACTIVE) begin
            row_q[sd_ba] <= sd_addr;
        end
    end

    // Mode register, init flag and refresh counter (wraps naturally at 16 bits)
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            cl_q        <= 3'd3;
            init_done_q <= 1'b0;
            refresh_q   <= 16'd0;
        end else begin
            if (cmd == CMD_LOAD_MODE && mode_ok) begin
                cl_q        <= sd_addr[6:4];
                init_done_q <= 1'b1;
            end
            if (cmd == CMD_REFRESH) refresh_q <= refresh_q + 16'd1;
        end
    end

    // Byte-laned storage with a registered read port
    // NOTE: the array and its read register have no reset; contents survive rstn and map to block RAM.
    always_ff @(posedge clk_in) begin
        if (cmd == CMD_WRITE) begin
            if (!sd_dqm[0]) mem_lo[acc_idx] <= sd_data[7:0];
            if (!sd_dqm[1]) mem_hi[acc_idx] <= sd_data[15:8];
        end
        if (cmd == CMD_READ) rd_word_q <= {mem_hi[acc_idx], mem_lo[acc_idx]};
    end

    // CAS-latency pipeline and output register; a WRITE flushes it to free the bus
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            p1_vld_q  <= 1'b0;
            p1_cl3_q  <= 1'b0;
            p2_vld_q  <= 1'b0;
            p2_data_q <= 16'd0;
            dqm_q     <= 2'b00;
            oe_q      <= 2'b00;
            dout_q    <= 16'd0;
        end else begin
            // dqm_q holds the mask seen one edge before the output-load edge.
            dqm_q     <= sd_dqm;
            p1_vld_q  <= (cmd == CMD_READ);
            p1_cl3_q  <= (eff_cl == 3'd3);
            p2_vld_q  <= p1_vld_q && p1_cl3_q;
            p2_data_q <= rd_word_q;
            if (p2_vld_q) begin
                oe_q   <= ~dqm_q;
                dout_q <= p2_data_q;
            end else if (p1_vld_q && !p1_cl3_q) begin
                oe_q   <= ~dqm_q;
                dout_q <= rd_word_q;
            end else begin
                oe_q   <= 2'b00;
            end
            if (cmd == CMD_WRITE) begin
                p1_vld_q <= 1'b0;
                p2_vld_q <= 1'b0;
                oe_q     <= 2'b00;
            end
        end
    end

    assign sd_data[7:0]  = oe_q[0] ? dout_q[7:0]  : 8'bz;
    assign sd_data[15:8] = oe_q[1] ? dout_q[15:8] : 8'bz;

    assign init_done   = init_done_q;
    assign refresh_cnt = refresh_q;

`ifdef SDRAM_MODEL_CHECK_EN
    localparam logic [3:0] TRCD_M1 = 4'(TRCD - 1);

    logic [3:0]      open_q;
    logic [3:0][3:0] rcd_q;
    logic [2:0]      err_d;
    logic [2:0]      pend_q;
    logic            err_q;
    logic [2:0]      err_code_q;

    // Bank open flags and tRCD countdowns; only the checker observes them
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            open_q <= '0;
            rcd_q  <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (rcd_q[b] != 4'd0) rcd_q[b] <= rcd_q[b] - 4'd1;
            end
            case (cmd)
                CMD_ACTIVE: begin
                    open_q[sd_ba] <= 1'b1;
                    rcd_q[sd_ba]  <= TRCD_M1;
                end
                CMD_READ, CMD_WRITE: if (sd_addr[10]) open_q[sd_ba] <= 1'b0;
                CMD_PRECHARGE: begin
                    if (sd_addr[10]) open_q <= '0;
                    else             open_q[sd_ba] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Error classification; later tests override earlier ones so the highest code wins
    always_comb begin
        err_d = 3'd0;
        case (cmd)
            CMD_LOAD_MODE: begin
                if (|open_q)  err_d = 3'd4;
                if (!mode_ok) err_d = 3'd5;
            end
            CMD_ACTIVE: if (open_q[sd_ba]) err_d = 3'd2;
            CMD_READ, CMD_WRITE: begin
                if (!open_q[sd_ba])         err_d = 3'd1;
                if (rcd_q[sd_ba] != 4'd0)   err_d = 3'd3;
                if (!init_done_q)           err_d = 3'd6;
            end
            CMD_REFRESH: if (|open_q) err_d = 3'd4;
            default: ;
        endcase
    end

    // Errors are staged for one cycle, then published as a sticky flag plus last code
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            pend_q     <= 3'd0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            pend_q <= err_d;
            if (pend_q != 3'd0) begin
                err_q      <= 1'b1;
                err_code_q <= pend_q;
            end
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
`else
    assign err      = 1'b0;
    assign err_code = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_chip_model.sv
// Self-checking bench for sdram_chip_model. Expected read slots are queued when
// a READ is issued and compared by a monitor when the slot comes due; every
// other cycle the monitor expects a released bus (pulled down to 0).
`timescale 1ns/1ps
module tb_sdram_chip_model;

`ifdef SDRAM_MODEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_NOP = 4'b0111;

    typedef struct {
        int unsigned slot;
        logic [15:0] data;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rstn = 1'b0;
    wire  [15:0] sd_data;
    logic [15:0] tb_drv = 16'h0000;
    logic        tb_drv_en = 1'b0;
    logic [12:0] sd_addr = 13'd0;
    logic [1:0]  sd_ba = 2'd0;
    logic [1:0]  sd_dqm = 2'd0;
    logic        sd_cs = 1'b1;
    logic        sd_ras = 1'b1;
    logic        sd_cas = 1'b1;
    logic        sd_we = 1'b1;
    logic        sd_cke = 1'b1;
    logic        init_done;
    logic [15:0] refresh_cnt;
    logic        err;
    logic [2:0]  err_code;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    assign sd_data = tb_drv_en ? tb_drv : 16'bz;
    pulldown pd_bus (sd_data);

    sdram_chip_model #(.MEM_AW(14), .TRCD(3)) dut (
        .clk_in      (clk_in),
        .rstn        (rstn),
        .sd_data     (sd_data),
        .sd_addr     (sd_addr),
        .sd_ba       (sd_ba),
        .sd_dqm      (sd_dqm),
        .sd_cs       (sd_cs),
        .sd_ras      (sd_ras),
        .sd_cas      (sd_cas),
        .sd_we       (sd_we),
        .sd_cke      (sd_cke),
        .init_done   (init_done),
        .refresh_cnt (refresh_cnt),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk_in = ~clk_in;

    // Monitor: cyc counts rising edges; sampled 2 ns after each edge.
    initial begin
        forever begin
            @(posedge clk_in);
            cyc++;
            #2;
            if (exp_q.size() != 0 && exp_q[0].slot == cyc) begin
                n_checks++;
                if (sd_data !== exp_q[0].data) begin
                    n_fail++;
                    $display("FAIL read_slot cyc=%0d got=%h expected=%h", cyc, sd_data, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else if (!tb_drv_en) begin
                n_checks++;
                if (sd_data !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL bus_idle cyc=%0d got=%h expected=0000 (released)", cyc, sd_data);
                end
            end
            if (exp_q.size() != 0 && exp_q[0].slot < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL read_slot_missed slot=%0d now=%0d expected=%h", exp_q[0].slot, cyc, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one command for the next rising edge; edge_n is that edge's number.
    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [1:0] dqm, input logic [15:0] wd, output int unsigned edge_n);
        @(negedge clk_in);
        {sd_cs, sd_ras, sd_cas, sd_we} = c;
        sd_ba  = ba;
        sd_addr = a;
        sd_dqm = dqm;
        sd_cke = 1'b1;
        edge_n = cyc + 1;
        if (c == C_WR) begin
            tb_drv    = wd;
            tb_drv_en = 1'b1;
            @(posedge clk_in);
            #1;
            tb_drv_en = 1'b0;
        end
    endtask

    task automatic nop(input int n, input logic [1:0] dqm);
        int unsigned e;
        for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'd0, dqm, 16'h0, e);
    endtask

    task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a);
        int unsigned e;
        issue(c, ba, a, 2'b00, 16'h0, e);
    endtask

    task automatic wr(input logic [1:0] ba, input logic [8:0] col, input logic [15:0] d, input logic [1:0] dqm);
        int unsigned e;
        issue(C_WR, ba, {4'b0000, col}, dqm, d, e);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [8:0] col, input logic [1:0] dqm,
                      input logic push, input logic [15:0] d, input int unsigned cl);
        int unsigned n;
        exp_t e;
        issue(C_RD, ba, {4'b0000, col}, dqm, 16'h0, n);
        if (push) begin
            e.slot = n + cl - 1;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got=%b expected=0", init_done); end
        n_checks++;
        if (refresh_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_refresh_cnt got=%h expected=0000", refresh_cnt); end
        n_checks++;
        if ({err, err_code} !== 4'b0000) begin n_fail++; $display("FAIL reset_err got=%b/%0d expected=0/0", err, err_code); end
        rstn = 1'b1;
        nop(2, 2'b00);
    endtask

    task automatic test_basic();
        cmd(C_PRE, 2'd0, 13'h400);
        cmd(C_LMR, 2'd0, 13'h230);
        nop(2, 2'b00);
        n_checks++;
        if (init_done !== 1'b1) begin n_fail++; $display("FAIL lmr_init_done got=%b expected=1", init_done); end
        cmd(C_ACT, 2'd2, 13'd1);
        nop(2, 2'b00);
        wr(2'd2, 9'd5, 16'hA55A, 2'b00);          // exactly TRCD edges after ACTIVE
        rd(2'd2, 9'd5, 2'b00, 1'b1, 16'hA55A, 3);  // read straight after write
        cmd(C_ACT, 2'd0, 13'd1);
        nop(2, 2'b00);
        wr(2'd0, 9'd5, 16'h0F0F, 2'b00);
        nop(4, 2'b00);
        n_checks++;
        if ({err, err_code} !== 4'b0000) begin n_fail++; $display("FAIL basic_no_err got=%b/%0d expected=0/0", err, err_code); end
    endtask

    task automatic test_dqm();
        wr(2'd2, 9'd6, 16'hFFFF, 2'b00);
        wr(2'd2, 9'd6, 16'h1234, 2'b01);           // lower lane masked
        rd(2'd2, 9'd6, 2'b00, 1'b1, 16'h12FF, 3);
        nop(3, 2'b00);
        rd(2'd2, 9'd6, 2'b00, 1'b1, 16'h00FF, 3);  // upper masked at N+1
        nop(1, 2'b10);
        nop(3, 2'b00);
        rd(2'd2, 9'd6, 2'b10, 1'b1, 16'h12FF, 3);  // mask at N is too early for CL=3
        nop(4, 2'b00);
    endtask

    task automatic test_back_to_back();
        rd(2'd2, 9'd5, 2'b00, 1'b1, 16'hA55A, 3);
        rd(2'd0, 9'd5, 2'b00, 1'b1, 16'h0F0F, 3);
        rd(2'd2, 9'd6, 2'b00, 1'b1, 16'h12FF, 3);
        nop(5, 2'b00);
    endtask

    task automatic test_cl2();
        cmd(C_PRE, 2'd0, 13'h400);
        cmd(C_LMR, 2'd0, 13'h220);
        cmd(C_ACT, 2'd2, 13'd1);
        nop(2, 2'b00);
        rd(2'd2, 9'd5, 2'b00, 1'b1, 16'hA55A, 2);
        nop(2, 2'b00);
        rd(2'd2, 9'd5, 2'b01, 1'b1, 16'hA500, 2);  // CL=2: mask sampled with the READ
        nop(3, 2'b00);
        cmd(C_PRE, 2'd0, 13'h400);
        cmd(C_LMR, 2'd0, 13'h250);                  // CL=5 rejected
        nop(2, 2'b00);
        n_checks++;
        if ({err, err_code} !== (CHK ? 4'b1101 : 4'b0000)) begin
            n_fail++; $display("FAIL lmr_bad_cl got=%b/%0d expected=%b/%0d", err, err_code, CHK, CHK ? 5 : 0);
        end
        cmd(C_ACT, 2'd2, 13'd1);
        nop(2, 2'b00);
        rd(2'd2, 9'd5, 2'b00, 1'b1, 16'hA55A, 2);  // still CL=2
        nop(3, 2'b00);
    endtask

    task automatic test_errors();
        cmd(C_ACT, 2'd1, 13'd3);
        nop(1, 2'b00);
        rd(2'd1, 9'd0, 2'b11, 1'b0, 16'h0, 2);      // TRCD-1 edges after ACTIVE
        nop(2, 2'b00);
        n_checks++;
        if ({err, err_code} !== (CHK ? 4'b1011 : 4'b0000)) begin
            n_fail++; $display("FAIL err_trcd got=%b/%0d expected=%b/%0d", err, err_code, CHK, CHK ? 3 : 0);
        end
        rd(2'd0, 9'd0, 2'b11, 1'b0, 16'h0, 2);      // bank 0 idle
        nop(2, 2'b00);
        n_checks++;
        if ({err, err_code} !== (CHK ? 4'b1001 : 4'b0000)) begin
            n_fail++; $display("FAIL err_idle_bank got=%b/%0d expected=%b/%0d", err, err_code, CHK, CHK ? 1 : 0);
        end
        cmd(C_ACT, 2'd1, 13'd3);                    // bank 1 already open
        nop(2, 2'b00);
        n_checks++;
        if ({err, err_code} !== (CHK ? 4'b1010 : 4'b0000)) begin
            n_fail++; $display("FAIL err_act_open got=%b/%0d expected=%b/%0d", err, err_code, CHK, CHK ? 2 : 0);
        end
        cmd(C_REF, 2'd0, 13'd0);
        nop(2, 2'b00);
        n_checks++;
        if ({err, err_code} !== (CHK ? 4'b1100 : 4'b0000)) begin
            n_fail++; $display("FAIL err_ref_open got=%b/%0d expected=%b/%0d", err, err_code, CHK, CHK ? 4 : 0);
        end
        n_checks++;
        if (refresh_cnt !== 16'd1) begin n_fail++; $display("FAIL refresh_one got=%h expected=0001", refresh_cnt); end
        cmd(C_LMR, 2'd0, 13'h231);                  // bad burst bits and banks open: 5 beats 4
        nop(2, 2'b00);
        n_checks++;
        if ({err, err_code} !== (CHK ? 4'b1101 : 4'b0000)) begin
            n_fail++; $display("FAIL err_priority got=%b/%0d expected=%b/%0d", err, err_code, CHK, CHK ? 5 : 0);
        end
    endtask

    task automatic test_write_cancel();
        int unsigned e;
        @(negedge clk_in);                          // READ with CKE low is ignored
        {sd_cs, sd_ras, sd_cas, sd_we} = C_RD;
        sd_ba = 2'd2; sd_addr = 13'd5; sd_dqm = 2'b00; sd_cke = 1'b0;
        nop(3, 2'b00);
        rd(2'd2, 9'd5, 2'b00, 1'b0, 16'h0, 2);
        wr(2'd2, 9'd7, 16'hBEEF, 2'b00);            // cancels the pending read
        nop(3, 2'b00);
        rd(2'd2, 9'd7, 2'b00, 1'b1, 16'hBEEF, 2);
        issue(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0, e);
        nop(3, 2'b00);
    endtask

    task automatic test_reset_mid_read();
        rd(2'd2, 9'd5, 2'b00, 1'b1, 16'hA55A, 2);
        nop(1, 2'b00);
        @(negedge clk_in);                          // middle of the output slot
        {sd_cs, sd_ras, sd_cas, sd_we} = C_NOP;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (sd_data !== 16'h0000) begin n_fail++; $display("FAIL async_release got=%h expected=0000", sd_data); end
        n_checks++;
        if (refresh_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_refresh got=%h expected=0000", refresh_cnt); end
        n_checks++;
        if ({init_done, err, err_code} !== 5'b00000) begin
            n_fail++; $display("FAIL rst_state got=%b/%b/%0d expected=0/0/0", init_done, err, err_code);
        end
        @(negedge clk_in);
        rstn = 1'b1;
        cmd(C_ACT, 2'd2, 13'd1);
        nop(2, 2'b00);
        rd(2'd2, 9'd5, 2'b00, 1'b1, 16'hA55A, 3);  // before LOAD_MODE: CL=3
        nop(3, 2'b00);
        n_checks++;
        if ({err, err_code} !== (CHK ? 4'b1110 : 4'b0000)) begin
            n_fail++; $display("FAIL err_no_init got=%b/%0d expected=%b/%0d", err, err_code, CHK, CHK ? 6 : 0);
        end
        cmd(C_PRE, 2'd0, 13'h400);
        cmd(C_LMR, 2'd0, 13'h230);
        cmd(C_ACT, 2'd2, 13'd1);
        nop(2, 2'b00);
        rd(2'd2, 9'd7, 2'b00, 1'b1, 16'hBEEF, 3);
        rd(2'd2, 9'd6, 2'b00, 1'b1, 16'h12FF, 3);
        nop(4, 2'b00);
    endtask

    task automatic test_refresh_wrap();
        cmd(C_PRE, 2'd0, 13'h400);
        for (int i = 0; i < 65535; i++) cmd(C_REF, 2'd0, 13'd0);
        nop(2, 2'b00);
        n_checks++;
        if (refresh_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL refresh_max got=%h expected=ffff", refresh_cnt); end
        cmd(C_REF, 2'd0, 13'd0);
        nop(2, 2'b00);
        n_checks++;
        if (refresh_cnt !== 16'h0000) begin n_fail++; $display("FAIL refresh_wrap got=%h expected=0000", refresh_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dqm();
        test_back_to_back();
        test_cl2();
        test_errors();
        test_write_cancel();
        test_reset_mid_read();
        test_refresh_wrap();
        nop(4, 2'b00);
        n_checks++;
        if ({err, err_code} !== (CHK ? 4'b1110 : 4'b0000)) begin
            n_fail++; $display("FAIL final_err got=%b/%0d expected=%b/%0d", err, err_code, CHK, CHK ? 6 : 0);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_chip_model.md
# sdram_chip_model

Synthesizable responder for the 16-bit SDRAM chip interface: the device side of the bus driven by the 68K SDRAM controller. It decodes CS/RAS/CAS/WE commands, tracks mode register, per-bank open rows and tRCD, and serves single-word reads and writes from an internal block-RAM array with the programmed CAS latency. It sits in simulation benches and FPGA loopback builds in place of the physical chip, and its optional protocol checker flags controller misbehaviour.

## Interface
- MEM_AW, 14: internal array address width; 2^MEM_AW 16-bit words.
- TRCD, 3: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- clk_in  in  1  chip clock; connect to controller's sd_clk. All logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- sd_data  inout  16  data bus; model drives only during read output slot.
- sd_addr  in  13  multiplexed row/column address.
- sd_ba  in  2  bank select.
- sd_dqm  in  2  byte masks, [1]=upper, [0]=lower.
- sd_cs, sd_ras, sd_cas, sd_we  in  1 each  command, active-low.
- sd_cke  in  1  clock enable.
- init_done  out  1  set by first valid LOAD_MODE.
- refresh_cnt  out  16  AUTO_REFRESH count, wraps 0xFFFF→0.
- err  out  1  sticky protocol-error flag.
- err_code  out  3  code of most recent error.

## Operation
- Command = {cs,ras,cas,we} sampled each edge with sd_cke=1; sd_cke=0: command ignored, read pipeline still advances.
- INHIBIT 1111, NOP 0111, BURST_TERMINATE 0110: no action.
- LOAD_MODE 0000: sd_addr[6:4]=CL, accept 2 or 3; sd_addr[2:0] must be 000. Valid → latch CL, init_done=1. Invalid → CL unchanged, error 5. Any bank open → error 4, mode still applied if valid.
- ACTIVE 0011: bank sd_ba ← open, row ← sd_addr, tRCD counter ← TRCD-1. Bank already open → error 2, row replaced.
- READ 0101 / WRITE 0100: column = sd_addr[8:0]; index = {row, ba, col[8:0]} truncated to MEM_AW LSBs. Bank idle → error 1, last latched row used. tRCD counter nonzero → error 3, access still performed. init_done=0 → error 6, CL=3 used. sd_addr[10]=1 → bank closed after access (auto-precharge).
- WRITE: data sampled same edge as command; lane written only if its dqm bit =0.
- PRECHARGE 0010: sd_addr[10]=1 closes all banks, else bank sd_ba. Idle bank: no error.
- AUTO_REFRESH 0001: refresh_cnt+1; any bank open → error 4.
- Reset: all banks idle, CL=3, init_done=0, refresh_cnt=0, err=0, err_code=0, sd_data hi-z, read pipeline flushed. Array contents retained.

## Timing
- READ sampled at edge N: model drives sd_data from just after edge N+CL-1 until just after edge N+CL; value valid at edge N+CL.
- Read DQM latency 2: lane masked (hi-z) if its dqm bit =1 at edge N+CL-2 (CL=2: edge N).
- Back-to-back reads each produce their own one-cycle slot; no bubble.
- WRITE sampled while read data pending: pending read output cancelled, bus released same cycle (no contention).
- WRITE then READ same address at next edge: read returns new data.
- tRCD: READ at ACTIVE+TRCD edges legal; ACTIVE+TRCD-1 → error 3.
- err, err_code update one cycle after offending edge; simultaneous errors report highest code.
- rstn low mid-read: sd_data hi-z immediately (asynchronous).

## Configuration
- SDRAM_MODEL_CHECK_EN defined: error detection active, err/err_code as above.
- Undefined: checker logic removed, err=0, err_code=0 constant; functional behaviour (row reuse, auto-precharge, cancellation) unchanged.

## Test plan
- Reset, PRECHARGE all, LOAD_MODE 0x230 → init_done=1, err=0; WRITE 0xA55A row 1 bank 2 col 5, READ → 0xA55A driven exactly at edge N+3, hi-z otherwise.
- WRITE 0x1234 dqm=01 over 0xFFFF → read 0x12FF; READ with dqm=10 at N+1 (CL=3) → upper lane hi-z, lower 0xFF.
- LOAD_MODE CL=2, READ → data valid at edge N+2; LOAD_MODE CL=5 → err=1, err_code=5, CL stays 2.
- ACTIVE then READ after 2 cycles (TRCD=3) → err_code=3; READ to idle bank → err_code=1; AUTO_REFRESH with open bank → err_code=4, refresh_cnt=1.
- READ then WRITE at edge N+1 → no read drive, write committed; rstn pulse mid-read → bus hi-z at once, refresh_cnt=0, array contents intact.
- 65536 AUTO_REFRESH commands → refresh_cnt wraps to 0; with SDRAM_MODEL_CHECK_EN undefined, all error stimuli leave err=0.
